// File: rtl/hbc_pkg.sv
// Shared types and default widths for the host bus controller.
package hbc_pkg;
  localparam int HBC_ADDR_W = 3;
  localparam int HBC_DATA_W = 8;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    WR_ACTIVE,
    WR_COMMIT,
    RD_ACTIVE
  } hbc_state_e;
endpackage

// File: rtl/hbc_sync.sv
// Generic multi-stage vector synchronizer for asynchronous host inputs.
module hbc_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[STAGES-1];
endmodule

// File: rtl/hbc_bus_controller.sv
// Host parallel-bus controller: strobe sync, host read/write sequencing and an
// 8x8 register file shared with an internal requester (host has priority).
module hbc_bus_controller
  import hbc_pkg::*;
#(
  parameter int ADDR_W      = HBC_ADDR_W,
  parameter int DATA_W      = HBC_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CSn,
  input  logic              WRn,
  input  logic              RDn,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  input  logic              int_req,
  input  logic              int_we,
  input  logic [ADDR_W-1:0] int_addr,
  input  logic [DATA_W-1:0] int_wdata,
  output logic [DATA_W-1:0] int_rdata,
  output logic              int_ack,
  output logic              host_wr_pulse,
  output logic [ADDR_W-1:0] host_wr_addr,
  output logic              proto_err
);
  localparam int SW    = 3 + ADDR_W + DATA_W;
  localparam int DEPTH = 1 << ADDR_W;

  logic [SW-1:0]     w_sync;
  logic              w_cs_n, w_wr_n, w_rd_n;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  // Synced strobes reset low so WAIT_IDLE holds until the host is truly idle.
  hbc_sync #(.WIDTH(SW), .STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d ({CSn, WRn, RDn, address, data_in}),
    .o_q (w_sync)
  );
  assign {w_cs_n, w_wr_n, w_rd_n, w_addr, w_data} = w_sync;

  hbc_state_e        r_state, w_next;
  logic              r_wr_n_prev, r_rd_n_prev;
  logic              w_wr_fall, w_rd_fall;
  logic [DATA_W-1:0] r_file [DEPTH];
  logic [ADDR_W-1:0] r_cap_addr, r_wr_addr;
  logic [DATA_W-1:0] r_cap_data, r_data_out, r_int_rdata;
  logic              r_data_oe, r_int_ack, r_wr_pulse, r_proto_err;
  logic              w_capture, w_rd_load, w_oe_next, w_proto, w_commit, w_grant;

  assign w_wr_fall = r_wr_n_prev & ~w_wr_n;
  assign w_rd_fall = r_rd_n_prev & ~w_rd_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= WAIT_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      WAIT_IDLE: if (w_wr_n && w_rd_n) w_next = IDLE;
      IDLE: begin
        if (!w_cs_n && !w_wr_n && !w_rd_n) w_next = WAIT_IDLE;
        else if (!w_cs_n && w_wr_fall)     w_next = WR_ACTIVE;
        else if (!w_cs_n && w_rd_fall)     w_next = RD_ACTIVE;
      end
      WR_ACTIVE: begin
        if (!w_rd_n)     w_next = WAIT_IDLE;
        else if (w_cs_n) w_next = IDLE;
        else if (w_wr_n) w_next = WR_COMMIT;
      end
      WR_COMMIT: w_next = IDLE;
      RD_ACTIVE: begin
        if (!w_wr_n)               w_next = WAIT_IDLE;
        else if (w_rd_n || w_cs_n) w_next = IDLE;
      end
      default: w_next = WAIT_IDLE;
    endcase
  end

  always_comb begin
    w_capture = (r_state == WR_ACTIVE) && (w_next == WR_COMMIT);
    w_rd_load = (r_state == IDLE) && (w_next == RD_ACTIVE);
    w_oe_next = (r_state == RD_ACTIVE) && (w_next == RD_ACTIVE);
    w_proto   = (r_state != WAIT_IDLE) && (w_next == WAIT_IDLE);
    w_commit  = (r_state == WR_COMMIT);
    // Holding off the cycle after an ack prevents a second ack for one held request.
    w_grant   = int_req && (r_state != WR_COMMIT) && !r_int_ack;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_n_prev <= 1'b0;
      r_rd_n_prev <= 1'b0;
      r_cap_addr  <= '0;
      r_cap_data  <= '0;
      r_data_out  <= '0;
      r_data_oe   <= 1'b0;
      r_int_rdata <= '0;
      r_int_ack   <= 1'b0;
      r_wr_pulse  <= 1'b0;
      r_wr_addr   <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_wr_n_prev <= w_wr_n;
      r_rd_n_prev <= w_rd_n;
      if (w_capture) begin
        r_cap_addr <= w_addr;
        r_cap_data <= w_data;
      end
      if (w_rd_load) r_data_out <= r_file[w_addr];
      r_data_oe   <= w_oe_next;
      r_proto_err <= w_proto;
      r_wr_pulse  <= w_commit;
      if (w_commit) r_wr_addr <= r_cap_addr;
      r_int_ack <= w_grant;
      if (w_grant && !int_we) r_int_rdata <= r_file[int_addr];
    end
  end

  // Host commit and internal grant are mutually exclusive by construction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_file[i] <= '0;
    end else if (w_commit) begin
      r_file[r_cap_addr] <= r_cap_data;
    end else if (w_grant && int_we) begin
      r_file[int_addr] <= int_wdata;
    end
  end

  assign data_out      = r_data_out;
  assign data_oe       = r_data_oe;
  assign int_rdata     = r_int_rdata;
  assign int_ack       = r_int_ack;
  assign host_wr_pulse = r_wr_pulse;
  assign host_wr_addr  = r_wr_addr;
  assign proto_err     = r_proto_err;
endmodule

// File: tb/tb_hbc_bus_controller.sv
// Randomized self-checking bench for hbc_bus_controller against a register-array model.
module tb_hbc_bus_controller;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       CSn, WRn, RDn;
  logic [2:0] address;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe;
  logic       int_req, int_we;
  logic [2:0] int_addr;
  logic [7:0] int_wdata, int_rdata;
  logic       int_ack, host_wr_pulse, proto_err;
  logic [2:0] host_wr_addr;

  logic [7:0] mem [8];
  int n_chk = 0;
  int n_err = 0;
  int pulse_cnt = 0;
  int proto_cnt = 0;

  hbc_bus_controller #(.ADDR_W(3), .DATA_W(8), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .CSn(CSn), .WRn(WRn), .RDn(RDn),
    .address(address), .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .int_req(int_req), .int_we(int_we), .int_addr(int_addr), .int_wdata(int_wdata),
    .int_rdata(int_rdata), .int_ack(int_ack), .host_wr_pulse(host_wr_pulse),
    .host_wr_addr(host_wr_addr), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (host_wr_pulse === 1'b1) pulse_cnt++;
    if (proto_err === 1'b1) proto_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic host_write(input logic [2:0] a, input logic [7:0] d, input bit abort);
    int p0;
    p0 = pulse_cnt;
    CSn = 1'b0; address = a; data_in = d; WRn = 1'b0;
    cyc(S + 4);
    if (abort) begin
      CSn = 1'b1;
      cyc(S + 3);
      WRn = 1'b1;
      cyc(S + 4);
      chk("abort_no_pulse", pulse_cnt - p0, 0);
    end else begin
      WRn = 1'b1;
      cyc(S + 4);
      chk("wr_pulse_once", pulse_cnt - p0, 1);
      chk("wr_addr", host_wr_addr, a);
      mem[a] = d;
      CSn = 1'b1;
      cyc(2);
    end
  endtask

  task automatic host_read(input logic [2:0] a);
    int k;
    CSn = 1'b0; address = a; RDn = 1'b0;
    k = 0;
    while (data_oe !== 1'b1 && k < S + 2) begin
      cyc(1);
      k++;
    end
    chk("rd_oe_rise", data_oe, 1);
    chk("rd_data", data_out, mem[a]);
    cyc(2);
    chk("rd_data_hold", data_out, mem[a]);
    RDn = 1'b1;
    k = 0;
    while (data_oe !== 1'b0 && k < S + 2) begin
      cyc(1);
      k++;
    end
    chk("rd_oe_fall", data_oe, 0);
    CSn = 1'b1;
    cyc(2);
  endtask

  task automatic int_access(input bit we, input logic [2:0] a, input logic [7:0] d);
    int k;
    int_req = 1'b1; int_we = we; int_addr = a; int_wdata = d;
    k = 0;
    do begin
      cyc(1);
      k++;
    end while (int_ack !== 1'b1 && k < 8);
    chk("int_ack", int_ack, 1);
    chk("int_latency", k, 1);
    if (!we) chk("int_rdata", int_rdata, mem[a]);
    else     mem[a] = d;
    int_req = 1'b0;
    cyc(1);
    chk("int_ack_single", int_ack, 0);
  endtask

  // Internal request raised in the host commit cycle to the same address.
  task automatic collide(input bit we, input logic [2:0] a, input logic [7:0] hd, input logic [7:0] id);
    int k, p0;
    p0 = pulse_cnt;
    CSn = 1'b0; address = a; data_in = hd; WRn = 1'b0;
    cyc(S + 4);
    WRn = 1'b1;
    cyc(S + 1);
    int_req = 1'b1; int_we = we; int_addr = a; int_wdata = id;
    k = 0;
    do begin
      cyc(1);
      k++;
    end while (int_ack !== 1'b1 && k < 8);
    chk("coll_ack", int_ack, 1);
    chk("coll_latency", k, 2);
    mem[a] = hd;
    if (we) mem[a] = id;
    else    chk("coll_rdata", int_rdata, hd);
    int_req = 1'b0;
    cyc(3);
    chk("coll_pulse", pulse_cnt - p0, 1);
    CSn = 1'b1;
    cyc(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0, q0;
    rst = 1'b1; CSn = 1'b0; WRn = 1'b0; RDn = 1'b1;
    address = 3'd0; data_in = 8'h00;
    int_req = 1'b0; int_we = 1'b0; int_addr = 3'd0; int_wdata = 8'h00;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    cyc(3);
    chk("rst_oe", data_oe, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_ack", int_ack, 0);
    chk("rst_pulse", host_wr_pulse, 0);
    chk("rst_proto", proto_err, 0);
    chk("rst_wr_addr", host_wr_addr, 0);

    // Strobe held low through reset release must not commit.
    p0 = pulse_cnt;
    rst = 1'b0;
    cyc(S + 3);
    WRn = 1'b1;
    cyc(S + 4);
    chk("rst_wr_ignored", pulse_cnt - p0, 0);
    CSn = 1'b1;
    cyc(2);
    int_access(1'b0, 3'd0, 8'h00);

    host_write(3'd3, 8'h5A, 1'b0);
    host_read(3'd3);
    host_write(3'd3, 8'hC3, 1'b1);
    host_read(3'd3);
    int_access(1'b0, 3'd3, 8'h00);

    collide(1'b1, 3'd3, 8'h22, 8'h11);
    int_access(1'b0, 3'd3, 8'h00);
    host_read(3'd3);
    collide(1'b0, 3'd5, 8'h77, 8'h00);

    // Both strobes low under chip select.
    p0 = proto_cnt; q0 = pulse_cnt;
    CSn = 1'b0; address = 3'd1; data_in = 8'hEE; WRn = 1'b0; RDn = 1'b0;
    cyc(S + 4);
    chk("proto_pulse", proto_cnt - p0, 1);
    chk("proto_oe", data_oe, 0);
    WRn = 1'b1; RDn = 1'b1;
    cyc(S + 3);
    CSn = 1'b1;
    cyc(2);
    chk("proto_no_commit", pulse_cnt - q0, 0);
    host_write(3'd1, 8'h3C, 1'b0);
    host_read(3'd1);

    // WRn falling during an active read.
    p0 = proto_cnt;
    CSn = 1'b0; address = 3'd1; RDn = 1'b0;
    cyc(S + 3);
    chk("rdwr_oe_before", data_oe, 1);
    WRn = 1'b0;
    cyc(S + 3);
    chk("rdwr_proto", proto_cnt - p0, 1);
    chk("rdwr_oe_after", data_oe, 0);
    WRn = 1'b1; RDn = 1'b1;
    cyc(S + 3);
    CSn = 1'b1;
    cyc(2);

    for (int it = 0; it < 40; it++) begin
      logic [2:0] a;
      logic [7:0] d;
      a = 3'($urandom_range(0, 7));
      d = 8'($urandom);
      case ($urandom_range(0, 3))
        0: host_write(a, d, ($urandom_range(0, 4) == 0));
        1: host_read(a);
        2: int_access(1'b1, a, d);
        default: int_access(1'b0, a, 8'h00);
      endcase
    end

    // Asynchronous reset during an active read.
    CSn = 1'b0; address = 3'd1; RDn = 1'b0;
    cyc(S + 3);
    chk("prerst_oe", data_oe, 1);
    rst = 1'b1;
    #1;
    chk("arst_oe", data_oe, 0);
    chk("arst_dout", data_out, 0);
    RDn = 1'b1; CSn = 1'b1;
    cyc(2);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    cyc(S + 3);
    for (int i = 0; i < 8; i++) int_access(1'b0, 3'(i), 8'h00);
    host_write(3'd6, 8'hA5, 1'b0);
    host_read(3'd6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
